// File: rtl/bch_eras_buf_ctrl_pkg.sv
// Shared definitions for the erasure BCH input-buffer controller:
// default code parameters, FSM state type and pointer/address types.
package bch_eras_buf_ctrl_pkg;

  localparam int M_DEF      = 4;   // Galois field order, bank address width
  localparam int N_DEF      = 15;  // codeword length in bits
  localparam int BNUM_W_DEF = 2;   // bank pointer width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    DROP  = 2'd2
  } state_t;

  typedef logic [BNUM_W_DEF-1:0] ptr_t;
  typedef logic [M_DEF-1:0]      data_t;

endpackage

// File: rtl/bch_eras_buf_ctrl_if.sv
// Source/buffer-write handshake bundle of the input-buffer controller.
// master: bit source plus downstream observers; slave: the controller.
interface bch_eras_buf_ctrl_if
  import bch_eras_buf_ctrl_pkg::*;
#(
  parameter int m       = M_DEF,
  parameter int pBNUM_W = BNUM_W_DEF
) ();

  logic               isop;
  logic               ival;
  logic               ieop;
  logic               idat;
  logic               ieras;
  logic               ifree;
  logic               ordy;
  logic               owrite;
  logic [pBNUM_W-1:0] owptr;
  logic [m-1:0]       owaddr;
  logic [1:0]         owdata;
  logic               ocommit;
  logic [pBNUM_W-1:0] ocommit_ptr;
  logic [pBNUM_W-1:0] orptr;
  logic [pBNUM_W:0]   oused;
  logic               oerr_len;
  logic               oerr_free;

  modport master (
    output isop, ival, ieop, idat, ieras, ifree,
    input  ordy, owrite, owptr, owaddr, owdata, ocommit, ocommit_ptr,
           orptr, oused, oerr_len, oerr_free
  );

  modport slave (
    input  isop, ival, ieop, idat, ieras, ifree,
    output ordy, owrite, owptr, owaddr, owdata, ocommit, ocommit_ptr,
           orptr, oused, oerr_len, oerr_free
  );

endinterface

// File: rtl/bch_eras_bank_fifo.sv
// Bank occupancy tracker: write/read bank pointers and committed-bank
// count. commit advances the write side, free releases the oldest bank.
module bch_eras_bank_fifo #(
  parameter int pBNUM_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clkena,
  input  logic               commit,
  input  logic               free,
  output logic [pBNUM_W-1:0] wptr,
  output logic [pBNUM_W-1:0] rptr,
  output logic [pBNUM_W:0]   used,
  output logic               err_free
);

  localparam int NBANK = 2**pBNUM_W;

  logic full;
  logic empty;
  logic do_free;
  logic do_commit;

  // occupancy decode; a free in the same cycle makes room for a commit
  always_comb begin
    empty     = (used == '0);
    full      = (used == (pBNUM_W+1)'(NBANK));
    do_free   = free & ~empty;
    do_commit = commit & (~full | do_free);
  end

  // pointer and counter update
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      used     <= '0;
      err_free <= 1'b0;
    end else if (clkena) begin
      err_free <= free & empty;
      if (do_commit) wptr <= wptr + pBNUM_W'(1);
      if (do_free)   rptr <= rptr + pBNUM_W'(1);
      case ({do_commit, do_free})
        2'b10:   used <= used + (pBNUM_W+1)'(1);
        2'b01:   used <= used - (pBNUM_W+1)'(1);
        default: used <= used;
      endcase
    end
  end

endmodule

// File: rtl/bch_eras_buf_ctrl.sv
// Bank allocation and frame sequencing for the erasure BCH input buffer.
// Optional statistics counters: define BCH_ERAS_BUF_CTRL_STAT_EN.
module bch_eras_buf_ctrl
  import bch_eras_buf_ctrl_pkg::*;
#(
  parameter int m       = M_DEF,
  parameter int n       = N_DEF,
  parameter int pBNUM_W = BNUM_W_DEF
) (
  input  logic                 iclk,
  input  logic                 ireset,
  input  logic                 iclkena,
  bch_eras_buf_ctrl_if.slave   bus
`ifdef BCH_ERAS_BUF_CTRL_STAT_EN
  ,
  output logic [15:0]          ostat_frames,
  output logic [15:0]          ostat_err,
  output logic [15:0]          ostat_stall
`endif
);

  localparam int           NBANK = 2**pBNUM_W;
  localparam logic [m-1:0] LAST  = m'(n-1);

  state_t             state;
  logic [m-1:0]       addr;
  logic [pBNUM_W-1:0] bank;

  logic               write_q;
  logic [m-1:0]       waddr_q;
  logic [pBNUM_W-1:0] wptr_q;
  logic [1:0]         wdata_q;
  logic               commit_q;
  logic [pBNUM_W-1:0] cptr_q;
  logic               err_len_q;

  logic [pBNUM_W-1:0] wptr;
  logic [pBNUM_W-1:0] rptr;
  logic [pBNUM_W:0]   used;
  logic               err_free;

  logic [pBNUM_W+1:0] occ;
  logic               rdy;
  logic [pBNUM_W-1:0] new_bank;
  logic [pBNUM_W-1:0] wbank;
  logic               accept;
  logic               restart;
  logic [m-1:0]       a;
  logic               last;

  bch_eras_bank_fifo #(.pBNUM_W(pBNUM_W)) u_fifo (
    .clk      (iclk),
    .rst      (ireset),
    .clkena   (iclkena),
    .commit   (commit_q),
    .free     (bus.ifree),
    .wptr     (wptr),
    .rptr     (rptr),
    .used     (used),
    .err_free (err_free)
  );

  // A commit pulse is one cycle ahead of the fifo count; counting it here
  // keeps a back-to-back sop from landing in the bank being committed.
  always_comb begin
    occ      = {1'b0, used} + (pBNUM_W+2)'(commit_q);
    rdy      = (state == FRAME) || (occ < (pBNUM_W+2)'(NBANK));
    new_bank = wptr + pBNUM_W'(commit_q);
    accept   = bus.ival & ((state == FRAME) | (bus.isop & rdy));
    restart  = (state == FRAME) & bus.isop;
    a        = ((state == FRAME) && !bus.isop) ? addr + m'(1) : '0;
    wbank    = (state == FRAME) ? bank : new_bank;
    last     = (a == LAST);
  end

  // frame FSM with registered write, commit and length-error outputs
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state     <= IDLE;
      addr      <= '0;
      bank      <= '0;
      write_q   <= 1'b0;
      waddr_q   <= '0;
      wptr_q    <= '0;
      wdata_q   <= '0;
      commit_q  <= 1'b0;
      cptr_q    <= '0;
      err_len_q <= 1'b0;
    end else if (iclkena) begin
      write_q   <= 1'b0;
      commit_q  <= 1'b0;
      err_len_q <= 1'b0;
      if (accept) begin
        write_q <= 1'b1;
        waddr_q <= a;
        wptr_q  <= wbank;
        wdata_q <= {bus.ieras, bus.idat};
        addr    <= a;
        bank    <= wbank;
        if (bus.ieop) begin
          state <= IDLE;
          if (last) begin
            commit_q <= 1'b1;
            cptr_q   <= wbank;
          end else begin
            err_len_q <= 1'b1;
          end
        end else if (last) begin
          state     <= DROP;
          err_len_q <= 1'b1;
        end else begin
          state <= FRAME;
        end
        if (restart) err_len_q <= 1'b1;
      end
    end
  end

  assign bus.ordy        = rdy;
  assign bus.owrite      = write_q;
  assign bus.owaddr      = waddr_q;
  assign bus.owptr       = wptr_q;
  assign bus.owdata      = wdata_q;
  assign bus.ocommit     = commit_q;
  assign bus.ocommit_ptr = cptr_q;
  assign bus.orptr       = rptr;
  assign bus.oused       = used;
  assign bus.oerr_len    = err_len_q;
  assign bus.oerr_free   = err_free;

`ifdef BCH_ERAS_BUF_CTRL_STAT_EN
  logic [16:0] err_sum;

  always_comb begin
    err_sum = {1'b0, ostat_err} + 17'(err_len_q) + 17'(err_free);
  end

  // saturating event counters
  always_ff @(posedge iclk) begin
    if (ireset) begin
      ostat_frames <= '0;
      ostat_err    <= '0;
      ostat_stall  <= '0;
    end else if (iclkena) begin
      if (commit_q && ostat_frames != '1) ostat_frames <= ostat_frames + 16'd1;
      ostat_err <= err_sum[16] ? '1 : err_sum[15:0];
      if ((state == IDLE) && bus.ival && bus.isop && !rdy && ostat_stall != '1)
        ostat_stall <= ostat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bch_eras_buf_ctrl.sv
// Bench for bch_eras_buf_ctrl: queue-based behavioural model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_bch_eras_buf_ctrl;

  logic clk;
  logic rst;
  logic ena;

  bch_eras_buf_ctrl_if #(.m(4), .pBNUM_W(2)) bus ();

`ifdef BCH_ERAS_BUF_CTRL_STAT_EN
  logic [15:0] st_frames, st_err, st_stall;
`endif

  bch_eras_buf_ctrl #(.m(4), .n(15), .pBNUM_W(2)) dut (
    .iclk    (clk),
    .ireset  (rst),
    .iclkena (ena),
    .bus     (bus)
`ifdef BCH_ERAS_BUF_CTRL_STAT_EN
    ,
    .ostat_frames (st_frames),
    .ostat_err    (st_err),
    .ostat_stall  (st_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  cq[$];          // committed banks, oldest first
  int  m_wptr;         // bank the next commit will claim
  bit  m_in;           // inside an accepted frame
  int  m_bank, m_addr;
  bit  e_write, e_commit, e_errlen, e_errfree, e_rdy;
  int  e_waddr, e_wptr, e_wdata, e_cptr, e_used, e_rptr;
  bit  started = 0;
  bit  ena_q = 0;
  int  pend, pend_bank, sz, newb, a;
  bit  rdy_pre, wrote;

  always @(posedge clk) begin
    started = 1;
    ena_q   = 0;
    if (rst) begin
      cq.delete();
      m_wptr = 0; m_in = 0; m_bank = 0; m_addr = 0;
      e_write = 0; e_commit = 0; e_errlen = 0; e_errfree = 0;
      e_waddr = 0; e_wptr = 0; e_wdata = 0; e_cptr = 0; e_used = 0; e_rptr = 0;
    end else if (ena) begin
      ena_q     = 1;
      pend      = e_commit;
      pend_bank = e_cptr;
      sz        = cq.size();
      rdy_pre   = m_in || (sz + pend < 4);
      newb      = (m_wptr + pend) % 4;
      // bank bookkeeping: the previous cycle's commit lands now
      e_errfree = bus.ifree && (sz == 0);
      if (bus.ifree && sz > 0) void'(cq.pop_front());
      if (pend != 0) begin
        cq.push_back(pend_bank);
        m_wptr = (pend_bank + 1) % 4;
      end
      // frame handling
      e_write = 0; e_commit = 0; e_errlen = 0; wrote = 0; a = 0;
      if (bus.ival) begin
        if (m_in) begin
          if (bus.isop) begin a = 0; e_errlen = 1; end
          else a = m_addr + 1;
          wrote = 1;
        end else if (bus.isop && rdy_pre) begin
          a = 0; m_bank = newb; m_in = 1; wrote = 1;
        end
      end
      if (wrote) begin
        e_write = 1;
        e_waddr = a;
        e_wptr  = m_bank;
        e_wdata = {bus.ieras, bus.idat};
        m_addr  = a;
        if (bus.ieop) begin
          m_in = 0;
          if (a == 14) begin e_commit = 1; e_cptr = m_bank; end
          else e_errlen = 1;
        end else if (a == 14) begin
          m_in = 0; e_errlen = 1;
        end
      end
      e_used = cq.size();
      e_rptr = (cq.size() > 0) ? cq[0] : m_wptr;
    end
    e_rdy = m_in || (cq.size() + e_commit < 4);
  end

  // ---------------- per-cycle compare + event counters ----------------
  int n_wr = 0, n_cm = 0, n_el = 0, n_ef = 0, last_cptr = -1;

  always @(negedge clk) begin
    if (started) begin
      check("ordy",        int'(bus.ordy),        int'(e_rdy));
      check("owrite",      int'(bus.owrite),      int'(e_write));
      check("owaddr",      int'(bus.owaddr),      e_waddr);
      check("owptr",       int'(bus.owptr),       e_wptr);
      check("owdata",      int'(bus.owdata),      e_wdata);
      check("ocommit",     int'(bus.ocommit),     int'(e_commit));
      check("ocommit_ptr", int'(bus.ocommit_ptr), e_cptr);
      check("orptr",       int'(bus.orptr),       e_rptr);
      check("oused",       int'(bus.oused),       e_used);
      check("oerr_len",    int'(bus.oerr_len),    int'(e_errlen));
      check("oerr_free",   int'(bus.oerr_free),   int'(e_errfree));
      if (ena_q) begin
        n_wr += int'(bus.owrite);
        n_ef += int'(bus.oerr_free);
        n_el += int'(bus.oerr_len);
        if (bus.ocommit) begin
          n_cm++;
          last_cptr = int'(bus.ocommit_ptr);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input bit v, input bit s, input bit e, input bit d,
                     input bit r, input bit f);
    bus.ival = v; bus.isop = s; bus.ieop = e; bus.idat = d; bus.ieras = r;
    bus.ifree = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drv(0, 0, 0, 0, 0, 0);
  endtask

  // bits first..last of a frame of length len; eop on bit len-1 if with_eop
  task automatic bits(input int first, input int last, input int len,
                      input bit with_eop);
    for (int i = first; i <= last; i++)
      drv(1, i == 0, with_eop && (i == len - 1), (i % 3) == 0, (i % 5) == 1, 0);
  endtask

  task automatic frame(input int len, input bit with_eop, input bit free_after);
    bits(0, len - 1, len, with_eop);
    if (free_after) drv(0, 0, 0, 0, 0, 1);
  endtask

  int s_wr, s_cm, s_el, s_ef;

  task automatic snap();
    s_wr = n_wr; s_cm = n_cm; s_el = n_el; s_ef = n_ef;
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    bus.ival = 0; bus.isop = 0; bus.ieop = 0; bus.idat = 0; bus.ieras = 0;
    bus.ifree = 0;
    idle(3);
    rst = 1'b0;
    check("rst_oused",  int'(bus.oused),  0);
    check("rst_ordy",   int'(bus.ordy),   1);
    check("rst_owrite", int'(bus.owrite), 0);
    check("rst_orptr",  int'(bus.orptr),  0);

    // single frame into bank 0
    snap();
    frame(15, 1, 0);
    idle(2);
    check("single_writes",  n_wr - s_wr, 15);
    check("single_commits", n_cm - s_cm, 1);
    check("single_cptr",    last_cptr,   0);
    check("single_oused",   int'(bus.oused), 1);

    // short frame: eop at addr 9, bank 1 reused by the next frame
    snap();
    frame(10, 1, 0);
    idle(2);
    check("short_errlen",  n_el - s_el, 1);
    check("short_commits", n_cm - s_cm, 0);
    check("short_oused",   int'(bus.oused), 1);
    frame(15, 1, 0);
    idle(2);
    check("reuse_cptr",  last_cptr, 1);
    check("reuse_oused", int'(bus.oused), 2);

    // commit coinciding with ifree at oused=2
    frame(15, 1, 1);
    idle(2);
    check("simul_cptr",  last_cptr, 2);
    check("simul_oused", int'(bus.oused), 2);
    check("simul_orptr", int'(bus.orptr), 1);

    // fill: two back-to-back frames into banks 3 and 0
    frame(15, 1, 0);
    frame(15, 1, 0);
    idle(2);
    check("fill_cptr",  last_cptr, 0);
    check("fill_oused", int'(bus.oused), 4);
    check("fill_ordy",  int'(bus.ordy), 0);
    snap();
    frame(15, 1, 0);
    idle(2);
    check("full_writes",  n_wr - s_wr, 0);
    check("full_commits", n_cm - s_cm, 0);
    drv(0, 0, 0, 0, 0, 1);
    check("free_oused", int'(bus.oused), 3);
    check("free_orptr", int'(bus.orptr), 2);
    check("free_ordy",  int'(bus.ordy),  1);

    // drain, then an ifree with nothing committed
    for (int i = 0; i < 3; i++) drv(0, 0, 0, 0, 0, 1);
    idle(1);
    snap();
    drv(0, 0, 0, 0, 0, 1);
    idle(1);
    check("errfree_count", n_ef - s_ef, 1);
    check("errfree_oused", int'(bus.oused), 0);

    // long frame: 16 bits without eop, then stray bits while dropping
    snap();
    frame(16, 0, 0);
    for (int i = 0; i < 4; i++) drv(1, 0, i == 3, 1, 0, 0);
    idle(2);
    check("long_writes",  n_wr - s_wr, 15);
    check("long_errlen",  n_el - s_el, 1);
    check("long_commits", n_cm - s_cm, 0);
    frame(15, 1, 0);
    idle(2);
    check("after_drop_cptr",  last_cptr, 1);
    check("after_drop_oused", int'(bus.oused), 1);

    // clock enable held low mid-frame
    snap();
    bits(0, 4, 15, 1);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) drv(1, 1, 1, 1, 1, 1);
    check("frozen_owaddr", int'(bus.owaddr), 4);
    ena = 1'b1;
    bits(5, 14, 15, 1);
    idle(2);
    check("ena_writes",  n_wr - s_wr, 15);
    check("ena_commits", n_cm - s_cm, 1);
    check("ena_errlen",  n_el - s_el, 0);
    check("ena_cptr",    last_cptr, 2);
    check("ena_oused",   int'(bus.oused), 2);

    // reset in the middle of a frame
    bits(0, 4, 15, 1);
    rst = 1'b1;
    drv(1, 0, 0, 1, 1, 0);
    rst = 1'b0;
    check("midrst_owrite",  int'(bus.owrite),  0);
    check("midrst_oused",   int'(bus.oused),   0);
    check("midrst_orptr",   int'(bus.orptr),   0);
    check("midrst_ordy",    int'(bus.ordy),    1);
    check("midrst_ocommit", int'(bus.ocommit), 0);
    check("midrst_owaddr",  int'(bus.owaddr),  0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
